instr_fetch_responder: RTL and testbench

- Memory-side responder for the program counter's fetch stream.
- Accepts 32-bit byte addresses on a valid/ready request channel and reads an internal instruction array of DEPTH words.
- Returns instructions in order on a valid/ready response channel, buffered in a small FIFO.
- Supports a flush (on taken branch) that discards stale in-flight and buffered responses; a load port lets the bench or boot logic fill the array.

---
 rtl/instr_fetch_responder.sv | 149 ++++++++++++++
 tb/tb_instr_fetch_responder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder: 2-stage array read pipeline feeding a credit-reserved response FIFO.
// Define IFR_PERF_EN to add the perf_req_cnt / perf_drop_cnt performance counters.
module instr_fetch_responder #(
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    input  logic                     flush,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic [31:0]              rsp_addr,
    output logic                     rsp_err,
    input  logic                     ld_en,
    input  logic [$clog2(DEPTH)-1:0] ld_addr,
    input  logic [DATA_W-1:0]        ld_data
`ifdef IFR_PERF_EN
    ,
    output logic [31:0]              perf_req_cnt,
    output logic [31:0]              perf_drop_cnt
`endif
);

    localparam int ADDR_W = $clog2(DEPTH);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [31:0]       addr;
        logic              err;
    } rsp_t;

    logic [DATA_W-1:0] mem [DEPTH];
    rsp_t              fifo [FIFO_DEPTH];

    logic              s1_valid;
    logic              s1_err;
    logic [31:0]       s1_addr;
    logic [DATA_W-1:0] s1_data;
    logic              s2_valid;
    rsp_t              s2;

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    in_flight;
    logic              accept;
    logic              push;
    logic              pop;
    logic              req_err;
    rsp_t              head;

    // Every request in S1/S2 already owns a FIFO slot, so the pipeline never has to stall.
    assign in_flight = {1'b0, count} + (CNT_W+1)'(s1_valid) + (CNT_W+1)'(s2_valid);
    assign req_ready = in_flight < (CNT_W+1)'(FIFO_DEPTH);
    assign accept    = req_valid && req_ready;
    assign pop       = rsp_valid && rsp_ready;
    assign push      = s2_valid && !flush;
    assign req_err   = (req_addr[1:0] != 2'b00) || (req_addr[31:ADDR_W+2] != '0);

    assign rsp_valid = (count != '0);
    assign head      = fifo[rd_ptr];
    assign rsp_data  = rsp_valid ? head.data : '0;
    assign rsp_addr  = rsp_valid ? head.addr : '0;
    assign rsp_err   = rsp_valid ? head.err  : 1'b0;

    // NOTE: storage arrays carry no reset; valid bits and pointers decide what is meaningful.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
        if (accept) begin
            s1_data <= mem[req_addr[ADDR_W+1:2]];
        end
        if (push) begin
            fifo[wr_ptr] <= s2;
        end
    end

    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s1_err   <= 1'b0;
            s1_addr  <= '0;
            s2_valid <= 1'b0;
            s2       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            // A request accepted alongside flush is the new target, so S1 ignores flush.
            s1_valid <= accept;
            if (accept) begin
                s1_addr <= req_addr;
                s1_err  <= req_err;
            end
            s2_valid <= s1_valid && !flush;
            if (s1_valid) begin
                s2.data <= s1_err ? '0 : s1_data;
                s2.addr <= s1_addr;
                s2.err  <= s1_err;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end

`ifdef IFR_PERF_EN
    logic [CNT_W:0] drop_n;
    logic [32:0]    drop_sum;

    // A pop in the flush cycle was delivered, so it is not a drop.
    assign drop_n   = in_flight - (CNT_W+1)'(pop);
    assign drop_sum = {1'b0, perf_drop_cnt} + 33'(drop_n);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_req_cnt  <= '0;
            perf_drop_cnt <= '0;
        end else begin
            if (accept && (perf_req_cnt != '1)) begin
                perf_req_cnt <= perf_req_cnt + 32'd1;
            end
            if (flush) begin
                perf_drop_cnt <= drop_sum[32] ? '1 : drop_sum[31:0];
            end
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_responder.sv
// Scoreboard bench for instr_fetch_responder: directed scenarios followed by randomized traffic.
// A queue of outstanding requests models the pipeline, FIFO, credit and latency behaviour.
module tb_instr_fetch_responder;

    localparam int DATA_W     = 32;
    localparam int DEPTH      = 256;
    localparam int FIFO_DEPTH = 4;

    logic              clk = 1'b0;
    logic              reset;
    logic              req_valid;
    logic              req_ready;
    logic [31:0]       req_addr;
    logic              flush;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_data;
    logic [31:0]       rsp_addr;
    logic              rsp_err;
    logic              ld_en;
    logic [7:0]        ld_addr;
    logic [DATA_W-1:0] ld_data;
`ifdef IFR_PERF_EN
    logic [31:0]       perf_req_cnt;
    logic [31:0]       perf_drop_cnt;
`endif

    instr_fetch_responder #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .flush(flush),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_addr(rsp_addr), .rsp_err(rsp_err),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data)
`ifdef IFR_PERF_EN
        , .perf_req_cnt(perf_req_cnt), .perf_drop_cnt(perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        logic        err;
        int          due;
    } exp_t;

    exp_t        q[$];
    logic [31:0] model_mem [DEPTH];
    int          cyc = 0;
    int          n_pass = 0;
    int          n_total = 0;
    int          n_acc = 0;
    longint      exp_req = 0;
    longint      exp_drop = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares handshake outputs and the response head against the model queue.
    always @(negedge clk) begin
        if (reset) begin
            check("req_ready", req_ready, q.size() < FIFO_DEPTH);
            check("rsp_valid", rsp_valid, (q.size() > 0) && (q[0].due <= cyc));
            if (rsp_valid && q.size() > 0 && q[0].due <= cyc) begin
                check("rsp_data", rsp_data, q[0].data);
                check("rsp_addr", rsp_addr, q[0].addr);
                check("rsp_err",  rsp_err,  q[0].err);
                if (rsp_ready) void'(q.pop_front());
            end
        end
    end

    // Reference model: runs after the monitor so a same-cycle pop is already retired.
    always @(negedge clk) begin
        exp_t e;
        #1;
        if (!reset) begin
            q.delete();
            exp_req  = 0;
            exp_drop = 0;
        end else begin
            if (flush) begin
                exp_drop += q.size();
                q.delete();
            end
            if (req_valid && req_ready) begin
                e.addr = req_addr;
                e.err  = (req_addr[1:0] != 2'b00) || (req_addr >= 32'(DEPTH * 4));
                e.data = e.err ? 32'd0 : model_mem[req_addr / 4];
                e.due  = cyc + 3;
                q.push_back(e);
                n_acc++;
                exp_req++;
            end
            if (ld_en) model_mem[ld_addr] = ld_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input logic [31:0] a);
        logic ok;
        req_valid = 1'b1;
        req_addr  = a;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            ok = req_ready;
            tick();
        end
        req_valid = 1'b0;
        if (!ok) check("req_accept_timeout", 0, 1);
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 100 && q.size() != 0; i++) tick();
        check("drain_empty", q.size(), 0);
    endtask

    function automatic logic [31:0] rand_addr();
        int r = $urandom_range(0, 9);
        if (r < 8)       return 32'($urandom_range(0, DEPTH - 1)) << 2;
        else if (r == 8) return (32'($urandom_range(0, DEPTH - 1)) << 2) | 32'($urandom_range(1, 3));
        else             return $urandom() | 32'h400;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int   n0;
        logic ok;
        reset = 1'b0; req_valid = 1'b0; req_addr = '0; flush = 1'b0;
        rsp_ready = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        #3;
        check("reset_rsp_valid", rsp_valid, 0);
        check("reset_rsp_data",  rsp_data,  0);
        check("reset_rsp_addr",  rsp_addr,  0);
        check("reset_rsp_err",   rsp_err,   0);
        check("reset_req_ready", req_ready, 1);
`ifdef IFR_PERF_EN
        check("reset_perf_req",  perf_req_cnt,  0);
        check("reset_perf_drop", perf_drop_cnt, 0);
`endif
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        // Fill the array through the load port.
        for (int i = 0; i < DEPTH; i++) begin
            ld_en   = 1'b1;
            ld_addr = 8'(i);
            if (i < 4)       ld_data = 32'hA0 + 32'(i);
            else if (i == 4) ld_data = 32'hB4;
            else if (i == 5) ld_data = 32'h55;
            else             ld_data = $urandom();
            tick();
        end
        ld_en = 1'b0;

        // Back-to-back streaming with the consumer always ready.
        rsp_ready = 1'b1;
        req(0); req(4); req(8); req(12);
        drain();

        // Backpressure: only FIFO_DEPTH requests may be in flight.
        rsp_ready = 1'b0;
        n0 = n_acc;
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_addr = 32'(16 + 4 * i);
            tick();
        end
        req_valid = 1'b0;
        check("backpressure_accepts", n_acc - n0, 4);
        check("backpressure_ready",   req_ready,  0);
        drain();

        // Misaligned and out-of-range addresses.
        req(32'h2); req(32'h400);
        drain();

        // Flush with a full pipeline; the request raised with it is the only survivor.
        rsp_ready = 1'b0;
        req(32'h20); req(32'h24); req(32'h28); req(32'h2C);
        tick();
`ifdef IFR_PERF_EN
        n0 = int'(perf_drop_cnt);
`endif
        ok = req_ready;
        flush = 1'b1; req_valid = 1'b1; req_addr = 32'h10;
        tick();
        flush = 1'b0;
        if (!ok) req(32'h10);
        else req_valid = 1'b0;
`ifdef IFR_PERF_EN
        check("flush_drop_cnt", 32'(int'(perf_drop_cnt) - n0), 4);
`endif
        drain();

        // Load and read of the same word in one cycle returns the old word.
        req_valid = 1'b1; req_addr = 32'h14;
        ld_en = 1'b1; ld_addr = 8'd5; ld_data = 32'hCC;
        tick();
        req_valid = 1'b0; ld_en = 1'b0;
        req(32'h14);
        drain();

        // Asynchronous reset while responses are buffered.
        rsp_ready = 1'b0;
        req(0); req(4);
        repeat (4) tick();
        check("pre_reset_valid", rsp_valid, 1);
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        check("async_reset_valid", rsp_valid, 0);
        check("async_reset_ready", req_ready, 1);
        tick();
        #2 reset = 1'b1;
        rsp_ready = 1'b1;
        req(8);
        drain();

        // Randomized traffic with loads, flushes and backpressure.
        for (int i = 0; i < 800; i++) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_addr  = rand_addr();
            rsp_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            ld_en     = ($urandom_range(0, 7) == 0);
            ld_addr   = 8'($urandom());
            ld_data   = $urandom();
            tick();
        end
        req_valid = 1'b0; flush = 1'b0; ld_en = 1'b0;
        drain();
`ifdef IFR_PERF_EN
        check("perf_req_cnt",  perf_req_cnt,  64'(exp_req));
        check("perf_drop_cnt", perf_drop_cnt, 64'(exp_drop));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
